plru_multiset: RTL and testbench

- Multi-set tree pseudo-LRU replacement engine for the L1 caches and the branch-target structures: one independent binary PLRU tree per set, 2**WAY_W ways per set.
- Accepts hit/fill updates and answers victim queries with one-cycle latency.
- Successor to the single-tree PLRU: adds a set dimension, invalid-way priority, same-set update/read bypass and optional way locking.

---
 rtl/plru_multiset.sv | 131 +++++++++++++
 tb/tb_plru_multiset.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/plru_multiset.sv
// Multi-set tree pseudo-LRU engine: per-set heap-indexed PLRU trees, one-cycle victim query.
// Optional PLRU_LOCK_EN macro enables per-way lock steering during the tree walk.
module plru_multiset #(
    parameter int unsigned WAY_W = 2,
    parameter int unsigned SET_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    upd_valid,
    input  logic [SET_W-1:0]        upd_set,
    input  logic [WAY_W-1:0]        upd_way,
    input  logic                    rd_req,
    input  logic [SET_W-1:0]        rd_set,
    input  logic [(2**WAY_W)-1:0]   rd_valid_mask,
    input  logic [(2**WAY_W)-1:0]   rd_lock_mask,
    output logic                    rd_valid,
    output logic [WAY_W-1:0]        victim_way,
    output logic                    all_locked
);

    localparam int unsigned WAYS = 2 ** WAY_W;
    localparam int unsigned SETS = 2 ** SET_W;

    // Node n lives at bit n; bit 0 of a heap has no node so the range starts at 1.
    logic [WAYS-1:1] tree [SETS];

    logic [WAYS-1:1] upd_tree_c;
    logic [WAYS-1:1] rd_tree_c;
    logic [WAY_W-1:0] walk_way_c;
    logic [WAY_W-1:0] inv_way_c;
    logic             inv_found_c;
    logic [WAY_W-1:0] victim_c;
    logic             all_locked_c;

    // Point every node on the accessed way's path away from it.
    always_comb begin
        int node;
        upd_tree_c = tree[upd_set];
        node = 1;
        for (int l = int'(WAY_W) - 1; l >= 0; l--) begin
            upd_tree_c[node] = ~upd_way[l];
            node = 2 * node + int'(upd_way[l]);
        end
    end

    // Same-set update in this cycle is visible to the query.
    always_comb begin
        if (upd_valid && (upd_set == rd_set)) begin
            rd_tree_c = upd_tree_c;
        end else begin
            rd_tree_c = tree[rd_set];
        end
    end

`ifdef PLRU_LOCK_EN
    // full_c[n] = every way beneath heap node n is locked; leaves sit at WAYS..2*WAYS-1.
    logic [2*WAYS-1:1] full_c;
    always_comb begin
        full_c = '0;
        full_c[2*WAYS-1:WAYS] = rd_lock_mask;
        for (int n = int'(WAYS) - 1; n >= 1; n--) begin
            full_c[n] = full_c[2*n] & full_c[2*n+1];
        end
    end
    assign all_locked_c = full_c[1];
`else
    logic unused_lock;
    assign unused_lock  = ^rd_lock_mask;
    assign all_locked_c = 1'b0;
`endif

    // Tree walk, steering around fully-locked subtrees when locking is built in.
    always_comb begin
        int   node;
        logic dir;
        walk_way_c = '0;
        node = 1;
        for (int l = int'(WAY_W) - 1; l >= 0; l--) begin
            dir = rd_tree_c[node];
`ifdef PLRU_LOCK_EN
            if (full_c[2*node + int'(dir)]) begin
                dir = ~dir;
            end
`endif
            walk_way_c[l] = dir;
            node = 2 * node + int'(dir);
        end
    end

    // Lowest-index invalid way.
    always_comb begin
        inv_found_c = 1'b0;
        inv_way_c   = '0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (!rd_valid_mask[w]) begin
                inv_found_c = 1'b1;
                inv_way_c   = WAY_W'(w);
            end
        end
    end

    always_comb begin
        victim_c = walk_way_c;
        if (inv_found_c) begin
            victim_c = inv_way_c;
        end else if (all_locked_c) begin
            victim_c = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < int'(SETS); s++) begin
                tree[s] <= '0;
            end
            rd_valid   <= 1'b0;
            victim_way <= '0;
            all_locked <= 1'b0;
        end else begin
            if (upd_valid) begin
                tree[upd_set] <= upd_tree_c;
            end
            rd_valid <= rd_req;
            if (rd_req) begin
                victim_way <= victim_c;
                all_locked <= all_locked_c;
            end
        end
    end

endmodule

// File: tb/tb_plru_multiset.sv
// Scoreboard bench for plru_multiset (WAY_W=2, SET_W=2); lock cases follow PLRU_LOCK_EN.
module tb_plru_multiset;

    logic       clk;
    logic       rst;
    logic       upd_valid;
    logic [1:0] upd_set;
    logic [1:0] upd_way;
    logic       rd_req;
    logic [1:0] rd_set;
    logic [3:0] rd_valid_mask;
    logic [3:0] rd_lock_mask;
    logic       rd_valid;
    logic [1:0] victim_way;
    logic       all_locked;

    plru_multiset #(.WAY_W(2), .SET_W(2)) dut (
        .clk(clk), .rst(rst),
        .upd_valid(upd_valid), .upd_set(upd_set), .upd_way(upd_way),
        .rd_req(rd_req), .rd_set(rd_set),
        .rd_valid_mask(rd_valid_mask), .rd_lock_mask(rd_lock_mask),
        .rd_valid(rd_valid), .victim_way(victim_way), .all_locked(all_locked)
    );

    typedef struct {
        int         due;
        logic       v;
        logic       chk;
        logic [1:0] victim;
        logic       lock;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   done = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_out(input logic v, input logic chk, input logic [1:0] vic,
                              input logic lk, input string nm);
        exp_t e;
        e.due = cyc + 1; e.v = v; e.chk = chk; e.victim = vic; e.lock = lk; e.name = nm;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        upd_valid     = 1'b0;
        rd_req        = 1'b0;
        rd_valid_mask = 4'hF;
        rd_lock_mask  = 4'h0;
    endtask

    task automatic upd(input logic [1:0] s, input logic [1:0] w);
        upd_valid = 1'b1; upd_set = s; upd_way = w;
        tick();
    endtask

    task automatic qry(input logic [1:0] s, input logic [1:0] vic, input logic lk, input string nm);
        rd_req = 1'b1; rd_set = s;
        expect_out(1'b1, 1'b1, vic, lk, nm);
        tick();
    endtask

    // Monitor: pops an expectation when its cycle comes due, flags any unexpected pulse.
    initial begin
        exp_t e;
        while (!done && cyc < 5000) begin
            @(negedge clk);
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                n_vec++;
                if (rd_valid !== e.v ||
                    (e.chk && (victim_way !== e.victim || all_locked !== e.lock))) begin
                    n_err++;
                    $display("FAIL %s: got valid=%b victim=%0d all_locked=%b, want valid=%b victim=%0d all_locked=%b",
                             e.name, rd_valid, victim_way, all_locked, e.v, e.victim, e.lock);
                end
            end else if (rd_valid !== 1'b0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_rd_valid: got rd_valid=%b at cycle %0d, want 0", rd_valid, cyc);
            end
        end
        n_vec++;
        if (!done || q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got done=%b pending=%0d, want done=1 pending=0", done, q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        rst = 1'b0; upd_valid = 1'b0; upd_set = '0; upd_way = '0;
        rd_req = 1'b0; rd_set = '0; rd_valid_mask = 4'hF; rd_lock_mask = 4'h0;
        tick();
        expect_out(1'b0, 1'b1, 2'd0, 1'b0, "reset_state");
        tick();
        rst = 1'b1;

        qry(2'd0, 2'd0, 1'b0, "reset_victim");
        expect_out(1'b0, 1'b0, 2'd0, 1'b0, "pulse_end");
        tick();

        upd(2'd1, 2'd0);
        qry(2'd1, 2'd2, 1'b0, "after_way0");
        upd(2'd1, 2'd0); upd(2'd1, 2'd1); upd(2'd1, 2'd2); upd(2'd1, 2'd3);
        qry(2'd1, 2'd0, 1'b0, "after_0123");

        // Different-set update must not disturb set 2, then same-set bypass.
        upd_valid = 1'b1; upd_set = 2'd3; upd_way = 2'd0;
        qry(2'd2, 2'd0, 1'b0, "other_set_upd");
        upd_valid = 1'b1; upd_set = 2'd2; upd_way = 2'd0;
        qry(2'd2, 2'd2, 1'b0, "bypass");

        qry(2'd3, 2'd2, 1'b0, "set3_after_way0");
        upd(2'd3, 2'd2);
        qry(2'd3, 2'd1, 1'b0, "set3_after_way2");
        upd(2'd3, 2'd1);
        qry(2'd3, 2'd3, 1'b0, "set3_after_way1");

        rd_valid_mask = 4'b1011;
        qry(2'd1, 2'd2, 1'b0, "invalid_way2");
        rd_valid_mask = 4'b0000;
        qry(2'd2, 2'd0, 1'b0, "all_invalid");

`ifdef PLRU_LOCK_EN
        rd_lock_mask = 4'b0011;
        qry(2'd0, 2'd2, 1'b0, "lock_low_half");
        rd_lock_mask = 4'b1111;
        qry(2'd0, 2'd0, 1'b1, "lock_all");
        rd_lock_mask = 4'b1000;
        qry(2'd3, 2'd2, 1'b0, "lock_way3");
        rd_lock_mask = 4'b1111; rd_valid_mask = 4'b1101;
        rd_req = 1'b1; rd_set = 2'd3;
        expect_out(1'b1, 1'b0, 2'd1, 1'b0, "invalid_beats_lock");
        tick();
`else
        rd_lock_mask = 4'b1111;
        qry(2'd0, 2'd0, 1'b0, "lock_ignored_all");
        rd_lock_mask = 4'b1000;
        qry(2'd3, 2'd3, 1'b0, "lock_ignored_way3");
`endif

        upd(2'd0, 2'd0);
        qry(2'd0, 2'd2, 1'b0, "pre_reset");
        rst = 1'b0; rd_req = 1'b1; rd_set = 2'd0;
        upd_valid = 1'b1; upd_set = 2'd0; upd_way = 2'd3;
        expect_out(1'b0, 1'b1, 2'd0, 1'b0, "reset_drops_query");
        tick();
        rst = 1'b1;
        qry(2'd0, 2'd0, 1'b0, "tree_cleared");
        qry(2'd1, 2'd0, 1'b0, "set1_cleared");

        tick(); tick();
        done = 1'b1;
    end

endmodule
